// File: rtl/score_bcd_display.sv
// score_bcd_display: tracks the session high score. It converts the current
// score and the high score to 3-digit BCD with a serial double-dabble engine
// that handles one bit per cycle. It drives six active-low 7-segment digits:
// hex2..hex0 show the current score and hex5..hex3 show the high score.
module score_bcd_display #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] score_current,
    input  logic       clear_high,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [7:0] high_score,
    output logic       new_high,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV_S,
        CONV_H,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK    = 7'b1111111;
    localparam logic [6:0] SEG_ZERO     = 7'b1000000;
    localparam logic [6:0] SEG_LZ_RESET = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

    state_t      state;
    state_t      state_next;
    logic [7:0]  snap_s;
    logic [7:0]  snap_h;
    logic [7:0]  shown_s;
    logic [7:0]  shown_h;
    logic [11:0] bcd;
    logic [11:0] bcd_s;
    logic [11:0] bcd_h;
    logic [11:0] bcd_step;
    logic [2:0]  bitcnt;
    logic        conv_bit;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    // Codes above 9 cannot occur and are shown dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to each nibble that is >= 5, then
    // shift left and bring in the next binary bit. The top nibble only keeps
    // its low three bits, because its MSB is shifted out anyway.
    function automatic logic [11:0] dabble(input logic [11:0] b, input logic in_bit);
        logic [3:0] lo;
        logic [3:0] mid;
        logic [2:0] hi;
        lo  = (b[3:0]  >= 4'd5) ? b[3:0]  + 4'd3 : b[3:0];
        mid = (b[7:4]  >= 4'd5) ? b[7:4]  + 4'd3 : b[7:4];
        hi  = (b[11:8] >= 4'd5) ? b[10:8] + 3'd3 : b[10:8];
        return {hi, mid, lo, in_bit};
    endfunction

    // Turn a 3-digit BCD group into {hundreds, tens, ones} segments.
    // Leading zeros are blanked when requested; the ones digit is always shown.
    function automatic logic [20:0] encode_group(input logic [11:0] b);
        logic blank_h;
        logic blank_t;
        blank_h = BLANK_LZ && (b[11:8] == 4'd0);
        blank_t = blank_h && (b[7:4] == 4'd0);
        return {blank_h ? SEG_BLANK : seg7(b[11:8]),
                blank_t ? SEG_BLANK : seg7(b[7:4]),
                seg7(b[3:0])};
    endfunction

    // Select the binary bit to feed in, MSB first, from the snapshot that is
    // being converted. Then form the next BCD value.
    always_comb begin
        conv_bit = (state == CONV_H) ? snap_h[3'd7 - bitcnt] : snap_s[3'd7 - bitcnt];
        bcd_step = dabble(bcd, conv_bit);
    end

    // High score tracking. A clear request overrides a new record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score <= 8'd0;
            new_high   <= 1'b0;
        end else if (clear_high) begin
            high_score <= 8'd0;
            new_high   <= 1'b0;
        end else if (score_current > high_score) begin
            high_score <= score_current;
            new_high   <= 1'b1;
        end else begin
            new_high   <= 1'b0;
        end
    end

    // Conversion state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A conversion starts whenever either displayed value
    // is stale. Each conversion phase lasts eight bit-cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if ((score_current != shown_s) || (high_score != shown_h)) state_next = LOAD;
            LOAD:    state_next = CONV_S;
            CONV_S:  if (bitcnt == 3'd7) state_next = CONV_H;
            CONV_H:  if (bitcnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status output: busy covers every cycle spent outside IDLE.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: snapshot, serial conversion, and registered display update.
    // Both groups are updated together, so the display stays coherent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_s  <= 8'd0;
            snap_h  <= 8'd0;
            shown_s <= 8'd0;
            shown_h <= 8'd0;
            bcd     <= 12'd0;
            bcd_s   <= 12'd0;
            bcd_h   <= 12'd0;
            bitcnt  <= 3'd0;
            hex0    <= SEG_ZERO;
            hex1    <= SEG_LZ_RESET;
            hex2    <= SEG_LZ_RESET;
            hex3    <= SEG_ZERO;
            hex4    <= SEG_LZ_RESET;
            hex5    <= SEG_LZ_RESET;
        end else begin
            case (state)
                LOAD: begin
                    snap_s <= score_current;
                    snap_h <= high_score;
                    bcd    <= 12'd0;
                    bitcnt <= 3'd0;
                end
                CONV_S: begin
                    if (bitcnt == 3'd7) begin
                        bcd_s  <= bcd_step;
                        bcd    <= 12'd0;
                        bitcnt <= 3'd0;
                    end else begin
                        bcd    <= bcd_step;
                        bitcnt <= bitcnt + 3'd1;
                    end
                end
                CONV_H: begin
                    if (bitcnt == 3'd7) begin
                        bcd_h  <= bcd_step;
                        bcd    <= 12'd0;
                        bitcnt <= 3'd0;
                    end else begin
                        bcd    <= bcd_step;
                        bitcnt <= bitcnt + 3'd1;
                    end
                end
                DONE: begin
                    {hex2, hex1, hex0} <= encode_group(bcd_s);
                    {hex5, hex4, hex3} <= encode_group(bcd_h);
                    shown_s <= snap_s;
                    shown_h <= snap_h;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// tb_score_bcd_display: compares score_bcd_display against a reference model
// built from decimal arithmetic and a conversion-cycle counter. The bench runs
// the directed scenarios first and then a stretch of random score traffic.
module tb_score_bcd_display;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam int CONV_CYCLES   = 18;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] score_current;
    logic       clear_high;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [7:0] high_score;
    logic       new_high;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_high;
    logic        m_new;
    int          m_cnt;
    logic [7:0]  m_snap_s;
    logic [7:0]  m_snap_h;
    logic [7:0]  m_shown_s;
    logic [7:0]  m_shown_h;
    logic [41:0] m_hex;

    score_bcd_display #(.BLANK_LZ(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .score_current (score_current),
        .clear_high    (clear_high),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5),
        .high_score    (high_score),
        .new_high      (new_high),
        .busy          (busy)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digitSeg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // Decimal digits of v, with leading-zero blanking, as {hundreds,tens,ones}.
    function automatic logic [20:0] groupHex(input int v);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return {(h == 0) ? BLANK : digitSeg(h),
                (h == 0 && t == 0) ? BLANK : digitSeg(t),
                digitSeg(o)};
    endfunction

    task automatic modelReset();
        m_high    = 8'd0;
        m_new     = 1'b0;
        m_cnt     = 0;
        m_snap_s  = 8'd0;
        m_snap_h  = 8'd0;
        m_shown_s = 8'd0;
        m_shown_h = 8'd0;
        m_hex     = {groupHex(0), groupHex(0)};
    endtask

    // Advance the model by one clock edge, using the inputs held before that edge.
    task automatic modelStep(input logic [7:0] s, input logic clr);
        logic [7:0] old_high;
        old_high = m_high;
        if (clr) begin
            m_high = 8'd0;
            m_new  = 1'b0;
        end else if (s > old_high) begin
            m_high = s;
            m_new  = 1'b1;
        end else begin
            m_new  = 1'b0;
        end
        if (m_cnt == 0) begin
            if (s != m_shown_s || old_high != m_shown_h) m_cnt = 1;
        end else if (m_cnt == CONV_CYCLES) begin
            m_hex     = {groupHex(int'(m_snap_h)), groupHex(int'(m_snap_s))};
            m_shown_s = m_snap_s;
            m_shown_h = m_snap_h;
            m_cnt     = 0;
        end else begin
            if (m_cnt == 1) begin
                m_snap_s = s;
                m_snap_h = old_high;
            end
            m_cnt++;
        end
    endtask

    task automatic compareAll();
        checkOutput("high_score", 64'(high_score), 64'(m_high));
        checkOutput("new_high", 64'(new_high), 64'(m_new));
        checkOutput("busy", 64'(busy), 64'(m_cnt != 0));
        checkOutput("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(m_hex));
    endtask

    // Drive inputs for one cycle from the falling edge. Step the model at the
    // rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input logic [7:0] s, input logic clr);
        score_current = s;
        clear_high    = clr;
        @(posedge clk);
        modelStep(s, clr);
        @(negedge clk);
        compareAll();
    endtask

    // Hold a score until the display matches both values, within a bounded wait.
    task automatic settle(input logic [7:0] s, output int busy_cycles, output int pulse_cycles);
        bit done;
        done = 1'b0;
        busy_cycles  = 0;
        pulse_cycles = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            applyStimulus(s, 1'b0);
            if (busy) busy_cycles++;
            if (new_high) pulse_cycles++;
            if (m_cnt == 0 && s == m_shown_s && m_high == m_shown_h) done = 1'b1;
        end
        checkOutput("settle_done", 64'(done), 64'd1);
    endtask

    // Asynchronous reset issued mid-cycle. Outputs must respond at once.
    task automatic doReset();
        reset      = 1'b1;
        clear_high = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int bc;
        int pc;
        int wait_cnt;
        logic [7:0] rs;

        reset         = 1'b1;
        score_current = 8'd0;
        clear_high    = 1'b0;
        modelReset();

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        compareAll();
        checkOutput("rst_hex0", 64'(hex0), 64'(ZERO));
        checkOutput("rst_hex3", 64'(hex3), 64'(ZERO));
        checkOutput("rst_hex_lz", 64'({hex5, hex4, hex2, hex1}), 64'({BLANK, BLANK, BLANK, BLANK}));
        checkOutput("rst_high", 64'(high_score), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (3) begin
            applyStimulus(8'd0, 1'b0);
            checkOutput("idle_busy", 64'(busy), 64'd0);
        end

        // Score rises from 0 to 7
        settle(8'd7, bc, pc);
        checkOutput("busy_len_7", 64'(bc), 64'(CONV_CYCLES));
        checkOutput("pulse_7", 64'(pc), 64'd1);
        checkOutput("high_7", 64'(high_score), 64'd7);
        checkOutput("hex0_7", 64'(hex0), 64'(7'b1111000));
        checkOutput("hex3_7", 64'(hex3), 64'(7'b1111000));
        checkOutput("lz_7", 64'({hex5, hex4, hex2, hex1}), 64'({BLANK, BLANK, BLANK, BLANK}));

        // Maximum score 255
        settle(8'd255, bc, pc);
        checkOutput("hex_cur_255", 64'({hex2, hex1, hex0}), 64'({7'b0100100, 7'b0010010, 7'b0010010}));
        checkOutput("hex_hi_255", 64'({hex5, hex4, hex3}), 64'({7'b0100100, 7'b0010010, 7'b0010010}));

        // Score 42, then a drop to 0
        doReset();
        settle(8'd42, bc, pc);
        settle(8'd0, bc, pc);
        checkOutput("pulse_drop", 64'(pc), 64'd0);
        checkOutput("high_42", 64'(high_score), 64'd42);
        checkOutput("hex_cur_0", 64'({hex2, hex1, hex0}), 64'({BLANK, BLANK, ZERO}));
        checkOutput("hex_hi_42", 64'({hex5, hex4, hex3}), 64'({BLANK, 7'b0011001, 7'b0100100}));

        // Score changes to 11 during the conversion of 10
        repeat (5) applyStimulus(8'd10, 1'b0);
        wait_cnt = 0;
        while (m_cnt != 0 && wait_cnt < 40) begin
            applyStimulus(8'd11, 1'b0);
            wait_cnt++;
        end
        checkOutput("first_conv_done", 64'(m_cnt == 0), 64'd1);
        checkOutput("hex_cur_10", 64'({hex2, hex1, hex0}), 64'({BLANK, 7'b1111001, ZERO}));
        checkOutput("gap_busy", 64'(busy), 64'd0);
        settle(8'd11, bc, pc);
        checkOutput("busy_len_11", 64'(bc), 64'(CONV_CYCLES));
        checkOutput("hex_cur_11", 64'({hex2, hex1, hex0}), 64'({BLANK, 7'b1111001, 7'b1111001}));

        // Clearing the high score
        doReset();
        settle(8'd50, bc, pc);
        settle(8'd20, bc, pc);
        applyStimulus(8'd20, 1'b1);
        checkOutput("clr_high", 64'(high_score), 64'd0);
        applyStimulus(8'd20, 1'b0);
        checkOutput("reload_high", 64'(high_score), 64'd20);
        checkOutput("reload_pulse", 64'(new_high), 64'd1);
        settle(8'd20, bc, pc);
        checkOutput("hex_20_20", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
                    64'({BLANK, 7'b0100100, ZERO, BLANK, 7'b0100100, ZERO}));

        // Reset asserted during the CONV_S phase
        repeat (5) applyStimulus(8'd99, 1'b0);
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        doReset();
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_high", 64'(high_score), 64'd0);
        checkOutput("abort_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
                    64'({BLANK, BLANK, ZERO, BLANK, BLANK, ZERO}));
        applyStimulus(8'd0, 1'b0);
        checkOutput("abort_idle", 64'(busy), 64'd0);

        // Random score traffic with occasional clears
        rs = 8'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 14) == 0) rs = 8'($urandom_range(0, 255));
            applyStimulus(rs, ($urandom_range(0, 59) == 0));
        end
        settle(rs, bc, pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Downstream consumer of the player block's `score_current[7:0]`.
- Tracks the session high score.
- Converts current and high score to 3-digit BCD with a sequential double-dabble engine (shift-add-3, one bit per cycle).
- Drives six active-low 7-segment HEX outputs: hex2..hex0 show the current score, hex5..hex3 show the high score.

Parameters:
- BLANK_LZ, 1, 1 blanks leading-zero digits; 0 shows all three digits of each number.

Ports:
- clk  input  1  system clock (same domain as the game's CLOCK)
- reset  input  1  asynchronous, active-high reset
- score_current  input  8  unsigned score from the player block
- clear_high  input  1  synchronous request to zero the high score
- hex0..hex5  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = current ones digit, hex3 = high-score ones digit
- high_score  output  8  registered high score
- new_high  output  1  one-cycle pulse when the high score increases
- busy  output  1  high while a conversion is in progress (any state other than IDLE)

Behaviour:
- Async reset (reset=1), effective immediately:
  - high_score=0, new_high=0, state=IDLE, busy=0.
  - Internal shown_s=0, shown_h=0.
  - hex0=hex3=7'b1000000 ("0").
  - hex1, hex2, hex4, hex5 = 7'b1111111 if BLANK_LZ=1, else 7'b1000000.
- High score register, every clock edge:
  - If clear_high: high_score<=0 and new_high<=0. clear_high has priority.
  - Else if score_current > high_score: high_score<=score_current and new_high<=1.
  - Else new_high<=0.
  - Rising scores therefore pulse new_high once per increment.
- FSM states: IDLE, LOAD, CONV_S, CONV_H, DONE.
  - IDLE: if score_current!=shown_s or high_score!=shown_h, go to LOAD; else stay.
  - LOAD (1 cycle):
    - snap_s<=score_current, snap_h<=high_score.
    - bcd<=12'd0, bitcnt<=0.
    - Go to CONV_S.
  - CONV_S (8 cycles): each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,snap_s} left by 1. Exactly 8 iterations, then copy bcd to bcd_s, clear bcd and bitcnt, and go to CONV_H.
  - CONV_H (8 cycles): same algorithm on snap_h, result to bcd_h, then go to DONE.
  - DONE (1 cycle): register all six hex outputs from bcd_s/bcd_h, shown_s<=snap_s, shown_h<=snap_h, then go to IDLE.
- Latency: hex outputs change on the clock edge ending DONE, 18 cycles after the edge leaving IDLE. busy is high for exactly 18 cycles per conversion.
- Inputs changing during a conversion are ignored; snapshots are stable. On return to IDLE the mismatch check retriggers. Displayed values only ever show complete, coherent conversions.
- Segment map, active-low {g..a}:

  | Digit | Segments  |
  |-------|-----------|
  | 0     | 1000000   |
  | 1     | 1111001   |
  | 2     | 0100100   |
  | 3     | 0110000   |
  | 4     | 0011001   |
  | 5     | 0010010   |
  | 6     | 0000010   |
  | 7     | 1111000   |
  | 8     | 0000000   |
  | 9     | 0010000   |

  Codes 10-15 are unreachable; drive 1111111 for them.
- Blanking when BLANK_LZ=1:
  - The hundreds digit is blank if it is 0.
  - The tens digit is blank if both hundreds and tens are 0.
  - The ones digit is always shown.
  - Applied independently to the score group and the high-score group.
- Width: max value 255 fits in 3 BCD digits (12-bit bcd register); no overflow possible.
- Reset asserted mid-conversion aborts it, returns all registers to reset values, and returns the FSM to IDLE.

Test Plan:
1. Assert reset for 3 cycles, score_current=0 → hex0=hex3=1000000; hex1, hex2, hex4, hex5=1111111; high_score=0; busy=0; busy stays 0 after release.
2. score_current 0→7 → new_high pulses for exactly 1 cycle; high_score=7; busy high for 18 cycles; then hex0=hex3=1111000 and the tens/hundreds digits stay blank.
3. score_current=255 → after conversion hex2=0100100, hex1=0010010, hex0=0010010; high group is identical.
4. Drive score 42, wait for idle, then score 0 → high_score stays 42 with no new_high; hex0=1000000, hex1=hex2=blank; hex4=0011001, hex3=0100100, hex5=blank.
5. score 10, then 11 on the 5th busy cycle → first result shows 10 (hex1=1111001, hex0=1000000); busy drops for 1 cycle, then reasserts for 18 cycles; final display is 11; no other intermediate value appears.
6. High=50, score_current=20, pulse clear_high for 1 cycle → high_score=0 on that edge, becomes 20 on the next edge with a new_high pulse, and the display settles to 20/20. Separately, assert reset during CONV_S → outputs take reset values immediately and FSM is IDLE.
